// File: rtl/iir_sample_host.sv
// iir_sample_host: frame buffer between a valid/ready sample stream and the
// IIR filter core. Fills an input buffer, serves the filter's free-running
// read port, captures its write port, then drains the filtered frame.
module iir_sample_host #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-low
    // Input sample stream
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    // Filtered sample stream
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_last,
    input  logic        out_ready,
    // Filter core memory-side interface
    output logic        flt_rst,
    input  logic        load,
    input  logic [19:0] RAddr,
    output logic [15:0] DIn,
    input  logic        WEN,
    input  logic [19:0] WAddr,
    input  logic [15:0] Yn,
    output logic        data_done,
    input  logic        Finish,
    // Status
    output logic        trunc
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e        state_q;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] rd_ptr_q;
    logic [19:0]   len_q;
    logic          trunc_q;
    logic          flt_rst_q;

    logic [15:0]   in_mem  [DEPTH];
    logic [15:0]   out_mem [DEPTH];

    logic          in_hs;
    logic          out_hs;
    logic          at_last_slot;
    logic          frame_end;
    logic          raddr_ok;
    logic          waddr_ok;
    logic          cap_en;

    // Handshakes and full-width address qualification; addresses at or
    // beyond len never alias onto the low buffer index bits.
    assign in_hs        = in_valid && in_ready;
    assign out_hs       = out_valid && out_ready;
    assign at_last_slot = (cnt_q == AW'(DEPTH - 1));
    assign frame_end    = in_hs && (in_last || at_last_slot);
    assign raddr_ok     = (RAddr < len_q);
    assign waddr_ok     = (WAddr < len_q);
    assign cap_en       = (state_q == RUN) && WEN && waddr_ok;

    // Stream-side outputs are decoded from the registered state only.
    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == DRAIN);
    assign out_last  = (state_q == DRAIN) && (20'(rd_ptr_q) == len_q - 20'd1);
    assign out_data  = (state_q == DRAIN) ? out_mem[rd_ptr_q] : 16'h0000;

    // Filter-side outputs; DIn and data_done are combinational on RAddr so
    // the filter sees the sample in the same cycle it presents the address.
    assign DIn       = (state_q == RUN && load && raddr_ok) ? in_mem[RAddr[AW-1:0]] : 16'h0000;
    assign data_done = (state_q == RUN) && !raddr_ok;
    assign flt_rst   = flt_rst_q;
    assign trunc     = trunc_q;

    // Input buffer write port: one accepted sample per cycle.
    // NOTE: buffer arrays carry no reset so they map onto plain RAM; their
    // contents are only read at addresses below len, which is reset to 0.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            in_mem[cnt_q] <= in_data;
        end
    end

    // Output buffer write port: captures filter results that fall inside the frame.
    always_ff @(posedge clk) begin
        if (cap_en) begin
            out_mem[WAddr[AW-1:0]] <= Yn;
        end
    end

    // Frame sequencer: FILL -> RUN -> DRAIN, with registered flt_rst/trunc.
    // NOTE: every register here is assigned with <= so all of them update
    // from the same pre-edge values; later assignments in the block override
    // earlier ones, which is how trunc "set" wins over "clear" below.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            rd_ptr_q  <= '0;
            len_q     <= '0;
            trunc_q   <= 1'b0;
            flt_rst_q <= 1'b1;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_hs) begin
                        cnt_q <= cnt_q + AW'(1);
                        if (cnt_q == '0) begin
                            trunc_q <= 1'b0;
                        end
                        if (frame_end) begin
                            len_q     <= 20'(cnt_q) + 20'd1;
                            state_q   <= RUN;
                            flt_rst_q <= 1'b0;
                            if (!in_last) begin
                                trunc_q <= 1'b1;
                            end
                        end
                    end
                end
                RUN: begin
                    if (Finish) begin
                        state_q   <= DRAIN;
                        flt_rst_q <= 1'b1;
                        rd_ptr_q  <= '0;
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        rd_ptr_q <= rd_ptr_q + AW'(1);
                        if (out_last) begin
                            state_q <= FILL;
                            cnt_q   <= '0;
                        end
                    end
                end
                default: begin
                    state_q   <= FILL;
                    flt_rst_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iir_sample_host.sv
// Directed testbench for iir_sample_host (DEPTH=8) with a small echo-filter
// model that returns Yn = DIn + 1 one cycle after each read.
module tb_iir_sample_host;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready = 1'b0;
    logic        flt_rst;
    logic        load = 1'b0;
    logic [19:0] RAddr = '0;
    logic [15:0] DIn;
    logic        WEN = 1'b0;
    logic [19:0] WAddr = '0;
    logic [15:0] Yn = '0;
    logic        data_done;
    logic        Finish = 1'b0;
    logic        trunc;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] stim[$];
    logic [15:0] exp_q[$];

    iir_sample_host #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .flt_rst(flt_rst), .load(load), .RAddr(RAddr), .DIn(DIn),
        .WEN(WEN), .WAddr(WAddr), .Yn(Yn), .data_done(data_done), .Finish(Finish),
        .trunc(trunc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer stim[0..n_drive-1], each held until accepted; stops once the host leaves FILL.
    task automatic send_frame(input int n_drive, input int exp_acc, input bit last_on_final, input string tag);
        int  acc;
        bit  hs;
        acc = 0;
        for (int cyc = 0; cyc < n_drive + 4 && acc < n_drive; cyc++) begin
            in_valid = 1'b1;
            in_data  = stim[acc];
            in_last  = last_on_final && (acc == n_drive - 1);
            @(negedge clk);
            hs = in_ready;
            tick();
            if (hs) acc++;
            if (acc > 0 && !in_ready) break;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({tag, "_accepted"}, acc, exp_acc);
    endtask

    // Echo filter: reads address k in RUN cycle k, writes DIn(k-1)+1 to k-1,
    // raises Finish the cycle after it first sees data_done.
    task automatic run_filter(input int exp_len, input int abort_at, input string tag);
        int          k;
        int          first_done;
        logic [15:0] prev_din;
        bit          done_prev;
        k          = 0;
        first_done = -1;
        prev_din   = '0;
        done_prev  = 1'b0;
        while (k < 64) begin
            load   = 1'b1;
            RAddr  = 20'(k);
            WEN    = (k > 0);
            WAddr  = (k > 0) ? 20'(k - 1) : 20'd0;
            Yn     = prev_din + 16'd1;
            Finish = done_prev;
            if (k == abort_at) begin
                #1;
                check({tag, "_done_before_rst"}, data_done, 1'b1);
                rst = 1'b0;
                #1;
                check({tag, "_rst_flt_rst"}, flt_rst, 1'b1);
                check({tag, "_rst_done"}, data_done, 1'b0);
                check({tag, "_rst_in_ready"}, in_ready, 1'b1);
                check({tag, "_rst_din"}, DIn, 16'h0000);
                load = 1'b0; WEN = 1'b0; Finish = 1'b0; RAddr = '0;
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b1;
                return;
            end
            @(negedge clk);
            check({tag, "_din"}, DIn, (k < exp_len) ? 32'(stim[k]) : 32'h0);
            prev_din = DIn;
            if (data_done && first_done < 0) first_done = k;
            done_prev = data_done;
            tick();
            k++;
            if (flt_rst) break;
        end
        load = 1'b0; WEN = 1'b0; Finish = 1'b0; RAddr = '0; WAddr = '0;
        check({tag, "_run_cycles"}, k, exp_len + 2);
        check({tag, "_first_done"}, first_done, exp_len);
    endtask

    // Drain exp_q; mode 1 applies the out_ready pattern 1,0,0,1 repeatedly.
    task automatic drain(input int mode, input string tag);
        int idx;
        int cyc;
        int n;
        bit hs;
        bit pat[4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        n   = exp_q.size();
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 4 * n + 8) begin
            out_ready = (mode == 1) ? pat[cyc % 4] : 1'b1;
            @(negedge clk);
            check({tag, "_valid"}, out_valid, 1'b1);
            check({tag, "_data"}, out_data, exp_q[idx]);
            check({tag, "_last"}, out_last, (idx == n - 1));
            hs = out_ready && out_valid;
            tick();
            if (hs) idx++;
            cyc++;
        end
        out_ready = 1'b0;
        check({tag, "_count"}, idx, n);
        check({tag, "_in_ready_after"}, in_ready, 1'b1);
        check({tag, "_valid_after"}, out_valid, 1'b0);
    endtask

    task automatic expect_echo();
        exp_q.delete();
        foreach (stim[i]) exp_q.push_back(stim[i] + 16'd1);
    endtask

    task automatic oor_cycle(input logic [19:0] ra, input logic ld, input logic wen,
                             input logic [19:0] wa, input logic [15:0] y, input logic fin,
                             input logic [15:0] exp_din, input logic exp_done, input string tag);
        RAddr = ra; load = ld; WEN = wen; WAddr = wa; Yn = y; Finish = fin;
        @(negedge clk);
        check({tag, "_din"}, DIn, exp_din);
        check({tag, "_done"}, data_done, exp_done);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held while the source offers data.
        in_valid = 1'b1;
        in_data  = 16'h5555;
        load     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_flt_rst", flt_rst, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_data_done", data_done, 1'b0);
        check("rst_din", DIn, 16'h0000);
        check("rst_trunc", trunc, 1'b0);
        in_valid = 1'b0;
        load     = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Three samples after reset: nothing was stored during reset.
        stim = '{16'h000A, 16'h000B, 16'h000C};
        send_frame(3, 3, 1'b1, "f3");
        run_filter(3, -1, "f3");
        expect_echo();
        drain(0, "f3");

        // Short frame.
        stim = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        send_frame(4, 4, 1'b1, "short");
        check("short_flt_rst_low", flt_rst, 1'b0);
        run_filter(4, -1, "short");
        check("short_flt_rst_high", flt_rst, 1'b1);
        expect_echo();
        drain(0, "short");

        // Backpressure during drain.
        stim = '{16'h1000, 16'h2000, 16'hFFFF};
        send_frame(3, 3, 1'b1, "bp");
        run_filter(3, -1, "bp");
        expect_echo();
        drain(1, "bp");

        // Truncation: 10 offered, DEPTH=8 accepted.
        stim.delete();
        for (int i = 0; i < 10; i++) stim.push_back(16'h0A00 + 16'(i));
        send_frame(10, 8, 1'b1, "trunc");
        check("trunc_set", trunc, 1'b1);
        run_filter(8, -1, "trunc");
        stim = stim[0:7];
        expect_echo();
        drain(0, "trunc");
        check("trunc_sticky", trunc, 1'b1);
        stim = '{16'h7FFF};
        send_frame(1, 1, 1'b1, "one");
        check("trunc_cleared", trunc, 1'b0);
        run_filter(1, -1, "one");
        expect_echo();
        drain(0, "one");

        // Out-of-range reads and writes, len=2.
        stim = '{16'h0010, 16'h0020};
        send_frame(2, 2, 1'b1, "oor");
        oor_cycle(20'd0, 1'b1, 1'b0, 20'd0,       16'h0000, 1'b0, 16'h0010, 1'b0, "oor_c0");
        oor_cycle(20'd1, 1'b1, 1'b1, 20'd0,       16'h1111, 1'b0, 16'h0020, 1'b0, "oor_c1");
        oor_cycle(20'd5, 1'b1, 1'b1, 20'd1,       16'h2222, 1'b0, 16'h0000, 1'b1, "oor_c2");
        oor_cycle(20'd8, 1'b1, 1'b1, 20'd2,       16'hDEAD, 1'b0, 16'h0000, 1'b1, "oor_c3");
        oor_cycle(20'd0, 1'b0, 1'b1, 20'hFFFFF,   16'hBEEF, 1'b0, 16'h0000, 1'b0, "oor_c4");
        oor_cycle(20'd0, 1'b1, 1'b1, 20'd8,       16'hCAFE, 1'b1, 16'h0010, 1'b0, "oor_c5");
        load = 1'b0; WEN = 1'b0; Finish = 1'b0; WAddr = '0;
        check("oor_flt_rst", flt_rst, 1'b1);
        exp_q = '{16'h1111, 16'h2222};
        drain(0, "oor");

        // Reset in RUN cycle 2, then a one-sample frame.
        stim = '{16'h0033, 16'h0044};
        send_frame(2, 2, 1'b1, "abort");
        run_filter(2, 2, "abort");
        stim = '{16'h0055};
        send_frame(1, 1, 1'b1, "post");
        run_filter(1, -1, "post");
        expect_echo();
        drain(0, "post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iir_sample_host.md
# iir_sample_host

Memory-side responder for the IIR filter core. Buffers one frame of 16-bit input samples arriving on a valid/ready stream, then releases the filter from reset and answers its free-running read port (RAddr/DIn) one sample per cycle. It captures the filter's write port (WAddr/Yn/WEN), asserts data_done at end of frame, and streams the filtered frame out on a valid/ready stream.

## Interface
Parameters:
- DEPTH, 1024: maximum frame length in samples; input and output buffers each hold DEPTH words.
- AW, 10: buffer address width, ceil(log2(DEPTH)).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  input sample valid
- in_data  in  16  input sample, two's complement
- in_last  in  1  marks final sample of frame
- in_ready  out  1  host accepts input sample
- out_valid  out  1  filtered sample valid
- out_data  out  16  filtered sample
- out_last  out  1  marks final filtered sample
- out_ready  in  1  downstream accepts filtered sample
- flt_rst  out  1  active-high reset to filter core, registered
- load  in  1  filter read enable
- RAddr  in  20  filter read address
- DIn  out  16  read data to filter, combinational
- WEN  in  1  filter write enable
- WAddr  in  20  filter write address
- Yn  in  16  filter write data
- data_done  out  1  end-of-frame indication to filter, combinational
- Finish  in  1  filter acknowledgement of data_done
- trunc  out  1  sticky: last frame hit DEPTH without in_last

## Operation
- States: FILL, RUN, DRAIN. Reset state is FILL.
- FILL:
  - in_ready=1.
  - Each in_valid&in_ready writes in_mem[cnt] and increments cnt.
  - Frame ends on an accepted sample with in_last=1, or on the accepted sample at cnt==DEPTH-1. In the latter case trunc is set if in_last=0.
  - At frame end: len<=cnt+1, next state RUN, flt_rst<=0.
  - trunc clears on the first accepted sample of a new frame.
- RUN:
  - in_ready=0; flt_rst=0.
  - DIn = (load && RAddr<len) ? in_mem[RAddr] : 0.
  - data_done = (RAddr>=len).
  - On each rising edge with WEN=1 and WAddr<len: out_mem[WAddr]<=Yn. Writes with WAddr>=len are dropped.
  - Finish=1 sampled at an edge -> DRAIN, flt_rst<=1, rd_ptr<=0.
- DRAIN:
  - out_valid=1; out_data=out_mem[rd_ptr]; out_last=(rd_ptr==len-1).
  - Handshake increments rd_ptr.
  - Handshake with out_last -> FILL, cnt<=0.
- Outside RUN: data_done=0, DIn=0, and WEN/Finish are ignored.
- Outside DRAIN: out_valid=0, out_last=0, out_data=0.
- In DRAIN, in_valid is ignored (in_ready=0); the upstream holds its sample.
- len is 20-bit internally; compares against RAddr/WAddr are done at full 20-bit width, so addresses >=DEPTH never alias.

## Timing
- Reset values: state=FILL, flt_rst=1, in_ready=1, out_valid=0, out_last=0, out_data=0, DIn=0, data_done=0, trunc=0, cnt=0, len=0, rd_ptr=0. Buffer contents are undefined.
- rst low in any state aborts the frame immediately and returns to FILL with the values above. The filter is held in reset via flt_rst=1.
- FILL: one sample per cycle at full throughput.
- RUN entry: the filter leaves reset with RAddr=0.
  - Cycle k of RUN presents RAddr=k, DIn=in_mem[k].
  - data_done first asserts in cycle len.
  - Finish is seen at the end of cycle len+1, so RUN lasts len+2 cycles.
- The last capture (WAddr=len-1) occurs at the edge ending cycle len.
- DRAIN: one sample per cycle while out_ready=1. out_valid/out_data stay stable while out_ready=0.
- Cycle after the final DRAIN handshake: in_ready=1.

## Test plan
- Reset: hold rst=0 while driving in_valid=1 -> in_ready=1, flt_rst=1, out_valid=0, data_done=0, no sample stored. Release, send 3 samples -> all 3 accepted.
- Short frame: send 4 samples 0x0100,0x0200,0x0300,0x0400 with in_last on the 4th; use a filter model that echoes Yn=DIn+1 -> RUN lasts exactly 6 cycles, data_done high from RUN cycle 4, drained out_data=0x0101,0x0201,0x0301,0x0401, out_last on the 4th, then in_ready=1.
- Backpressure: in DRAIN, toggle out_ready 1,0,0,1 -> out_data held constant across stall cycles, no sample skipped or duplicated.
- Truncation (DEPTH=8): send 10 samples, in_last on the 10th -> only 8 accepted, trunc=1, len=8. The next frame's first accepted sample clears trunc.
- Out-of-range writes: in RUN, drive WEN=1 with WAddr=len and WAddr=0xFFFFF -> out_mem unchanged; drive RAddr=len+3 -> DIn=0, data_done=1.
- Mid-frame reset: assert rst=0 in RUN cycle 2 -> flt_rst=1 asynchronously, state FILL, data_done=0. A following 1-sample frame completes with a RUN of 3 cycles.
